// File: rtl/key_buffer_ctrl.sv
// Purpose : circular-FIFO owner of the ram32x8 message store; filters PS/2 break codes from the keyboard stream.
// Latency : key pin edge -> sample 3 cycles, write 1 cycle; rd_req -> rd_valid 3+READ_LATENCY-1 cycles from IDLE.
// Backpr. : none; 1-deep write/read slots, extra bytes dropped (sticky overflow), empty reads flag rd_underflow.
//
// Ports   : clock/reset (async, active-high); key_complete/key_data from ps2_keyboard;
//           clear (sync flush); rd_req -> rd_valid/rd_data/rd_underflow; count/empty/full/overflow/busy status;
//           ram_address/ram_data/ram_wren/ram_q to the single-port RAM.
// Option  : define KEY_BUFFER_BACKSPACE_EN to make scan code 0x66 delete the newest entry instead of storing it.
module key_buffer_ctrl #(
  parameter int ADDR_WIDTH   = 5,
  parameter int DATA_WIDTH   = 8,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  key_complete,
  input  logic [DATA_WIDTH-1:0] key_data,
  input  logic                  clear,
  input  logic                  rd_req,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_underflow,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  empty,
  output logic                  full,
  output logic                  overflow,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic                  ram_wren,
  input  logic [DATA_WIDTH-1:0] ram_q
);

  localparam logic [ADDR_WIDTH:0]   CNT_FULL  = (ADDR_WIDTH+1)'(2**ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = ADDR_WIDTH'(1);
  localparam logic [DATA_WIDTH-1:0] BRK_CODE  = DATA_WIDTH'(8'hF0);
  localparam logic                  WAIT_LAST = 1'(READ_LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_RD_ADDR, S_RD_WAIT} state_t;

  state_t                  r_state, w_state_nxt;
  logic                    r_kc_s1, r_kc_s2, r_kc_s3;
  logic                    r_break, r_wr_pend, r_rd_pend, r_overflow;
  logic [DATA_WIDTH-1:0]   r_wr_byte, r_rd_data, r_ram_data;
  logic [ADDR_WIDTH-1:0]   r_wr_ptr, r_rd_ptr, r_ram_address;
  logic [ADDR_WIDTH:0]     r_count;
  logic                    r_rd_valid, r_rd_underflow, r_ram_wren, r_wait_cnt;

  logic                    w_key_edge, w_is_brk, w_storable, w_store;
  logic                    w_wr_accept, w_wr_drop, w_rd_underflow, w_rd_accept;
  logic                    w_wr_pend_eff, w_rd_pend_eff, w_wait_last, w_bs_hold;
  logic [DATA_WIDTH-1:0]   w_wr_byte_eff;

  assign w_key_edge = r_kc_s2 & ~r_kc_s3;
  assign w_is_brk   = (key_data == BRK_CODE);
  // The byte after 0xF0 is the released key's code and is swallowed with it.
  assign w_storable = w_key_edge & ~r_break & ~w_is_brk;

`ifdef KEY_BUFFER_BACKSPACE_EN
  localparam logic [DATA_WIDTH-1:0] BS_CODE = DATA_WIDTH'(8'h66);
  logic r_bs_pend;
  logic w_is_bs;
  assign w_is_bs   = (key_data == BS_CODE);
  assign w_store   = w_storable & ~w_is_bs;
  // A backspace is applied from IDLE only, so it never races a pointer update.
  assign w_bs_hold = r_bs_pend;
`else
  assign w_store   = w_storable;
  assign w_bs_hold = 1'b0;
`endif

  assign w_wr_accept    = w_store & ~r_wr_pend & ~full;
  assign w_wr_drop      = w_store & (r_wr_pend | full);
  assign w_rd_underflow = rd_req & empty & ~r_wr_pend;
  assign w_rd_accept    = rd_req & ~w_rd_underflow & ~r_rd_pend;

  // Requests arriving this cycle are visible to IDLE immediately to save a cycle.
  assign w_wr_pend_eff  = r_wr_pend | w_wr_accept;
  assign w_wr_byte_eff  = r_wr_pend ? r_wr_byte : key_data;
  assign w_rd_pend_eff  = r_rd_pend | w_rd_accept;
  assign w_wait_last    = (r_wait_cnt == WAIT_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_bs_hold)                    w_state_nxt = S_IDLE;
        else if (w_wr_pend_eff)           w_state_nxt = S_WRITE;
        else if (w_rd_pend_eff && !empty) w_state_nxt = S_RD_ADDR;
      end
      S_WRITE:   w_state_nxt = S_IDLE;
      S_RD_ADDR: w_state_nxt = S_RD_WAIT;
      S_RD_WAIT: if (w_wait_last) w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
    if (clear) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_kc_s1 <= 1'b0; r_kc_s2 <= 1'b0; r_kc_s3 <= 1'b0;
      r_break <= 1'b0; r_wr_pend <= 1'b0; r_rd_pend <= 1'b0; r_overflow <= 1'b0;
      r_wr_byte <= '0; r_rd_data <= '0; r_ram_data <= '0;
      r_wr_ptr <= '0; r_rd_ptr <= '0; r_ram_address <= '0; r_count <= '0;
      r_rd_valid <= 1'b0; r_rd_underflow <= 1'b0; r_ram_wren <= 1'b0; r_wait_cnt <= 1'b0;
`ifdef KEY_BUFFER_BACKSPACE_EN
      r_bs_pend <= 1'b0;
`endif
    end else begin
      r_kc_s1 <= key_complete;
      r_kc_s2 <= r_kc_s1;
      r_kc_s3 <= r_kc_s2;
      r_rd_valid     <= 1'b0;
      r_rd_underflow <= 1'b0;
      // RAM strobes are registered; a write already on the bus when clear hits still completes.
      r_ram_wren <= (w_state_nxt == S_WRITE);
      if (r_state == S_IDLE && w_state_nxt == S_WRITE) begin
        r_ram_address <= r_wr_ptr;
        r_ram_data    <= w_wr_byte_eff;
      end else if (r_state == S_IDLE && w_state_nxt == S_RD_ADDR) begin
        r_ram_address <= r_rd_ptr;
      end
      if (clear) begin
        r_break <= 1'b0; r_wr_pend <= 1'b0; r_rd_pend <= 1'b0; r_overflow <= 1'b0;
        r_wr_ptr <= '0; r_rd_ptr <= '0; r_count <= '0; r_wait_cnt <= 1'b0;
`ifdef KEY_BUFFER_BACKSPACE_EN
        r_bs_pend <= 1'b0;
`endif
      end else begin
        if (w_key_edge) r_break <= ~r_break & w_is_brk;
        if (w_wr_drop) r_overflow <= 1'b1;
        if (w_wr_accept) begin
          r_wr_pend <= 1'b1;
          r_wr_byte <= key_data;
        end
        if (w_rd_underflow) r_rd_underflow <= 1'b1;
        if (w_rd_accept)    r_rd_pend      <= 1'b1;
        case (r_state)
          S_WRITE: begin
            r_wr_ptr  <= r_wr_ptr + PTR_ONE;
            r_count   <= r_count + CNT_ONE;
            r_wr_pend <= 1'b0;
          end
          S_RD_ADDR: r_wait_cnt <= 1'b0;
          S_RD_WAIT: begin
            if (w_wait_last) begin
              r_rd_data  <= ram_q;
              r_rd_valid <= 1'b1;
              r_rd_ptr   <= r_rd_ptr + PTR_ONE;
              r_count    <= r_count - CNT_ONE;
              r_rd_pend  <= 1'b0;
            end else begin
              r_wait_cnt <= r_wait_cnt + 1'b1;
            end
          end
          default: ;
        endcase
`ifdef KEY_BUFFER_BACKSPACE_EN
        if (r_state == S_IDLE && r_bs_pend) begin
          r_bs_pend <= 1'b0;
          if (!empty) begin
            r_wr_ptr <= r_wr_ptr - PTR_ONE;
            r_count  <= r_count - CNT_ONE;
          end
        end
        if (w_storable && w_is_bs) r_bs_pend <= 1'b1;
`endif
      end
    end
  end

  assign rd_valid     = r_rd_valid;
  assign rd_data      = r_rd_data;
  assign rd_underflow = r_rd_underflow;
  assign count        = r_count;
  assign empty        = (r_count == '0);
  assign full         = (r_count == CNT_FULL);
  assign overflow     = r_overflow;
  assign busy         = (r_state != S_IDLE);
  assign ram_address  = r_ram_address;
  assign ram_data     = r_ram_data;
  assign ram_wren     = r_ram_wren;

endmodule

// File: tb/tb_key_buffer_ctrl.sv
module tb_key_buffer_ctrl;
  localparam int AW = 5;
  localparam int DW = 8;
  localparam int RL = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          key_complete = 1'b0;
  logic [DW-1:0] key_data = '0;
  logic          clear = 1'b0;
  logic          rd_req = 1'b0;
  logic          rd_valid, rd_underflow, empty, full, overflow, busy, ram_wren;
  logic [DW-1:0] rd_data, ram_data, ram_q;
  logic [AW:0]   count;
  logic [AW-1:0] ram_address;

  always #5 clk = ~clk;

  key_buffer_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(RL)) dut (
    .clock(clk), .reset(rst), .key_complete(key_complete), .key_data(key_data),
    .clear(clear), .rd_req(rd_req), .rd_valid(rd_valid), .rd_data(rd_data),
    .rd_underflow(rd_underflow), .count(count), .empty(empty), .full(full),
    .overflow(overflow), .busy(busy), .ram_address(ram_address), .ram_data(ram_data),
    .ram_wren(ram_wren), .ram_q(ram_q)
  );

  // Single-port RAM with registered address and optional output register.
  logic [DW-1:0] mem [32];
  logic [AW-1:0] addr_r, last_wr_addr;
  logic [DW-1:0] q_r;
  always @(posedge clk) begin
    if (ram_wren) begin
      mem[ram_address] <= ram_data;
      last_wr_addr     <= ram_address;
    end
    addr_r <= ram_address;
    q_r    <= mem[addr_r];
  end
  assign ram_q = (RL == 1) ? mem[addr_r] : q_r;

  int checks = 0;
  int errors = 0;

  // Reference model: buffer contents as a plain queue plus break/overflow flags.
  logic [7:0] model_q [$];
  logic [7:0] exp_q [$];
  int         exp_uf = 0;
  bit         m_brk = 0;
  bit         m_ovf = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_key(input logic [7:0] b);
    if (m_brk)                     m_brk = 0;
    else if (b == 8'hF0)           m_brk = 1;
    else if (model_q.size() == 32) m_ovf = 1;
    else                           model_q.push_back(b);
  endtask

  task automatic model_read();
    if (model_q.size() == 0) exp_uf++;
    else                     exp_q.push_back(model_q.pop_front());
  endtask

  task automatic model_clear();
    model_q.delete();
    m_brk = 0;
    m_ovf = 0;
  endtask

  task automatic press(input logic [7:0] b);
    model_key(b);
    @(posedge clk); #1;
    key_data = b;
    key_complete = 1'b1;
    repeat (4) @(posedge clk);
    #1 key_complete = 1'b0;
    repeat (6) @(posedge clk);
  endtask

  task automatic do_read();
    model_read();
    @(posedge clk); #1 rd_req = 1'b1;
    @(posedge clk); #1 rd_req = 1'b0;
    repeat (8) @(posedge clk);
  endtask

  task automatic do_clear();
    model_clear();
    @(posedge clk); #1 clear = 1'b1;
    @(posedge clk); #1 clear = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic chk_state(input string tag);
    @(negedge clk);
    chk({tag, "_count"},    32'(count),    32'(model_q.size()));
    chk({tag, "_empty"},    32'(empty),    32'(model_q.size() == 0));
    chk({tag, "_full"},     32'(full),     32'(model_q.size() == 32));
    chk({tag, "_overflow"}, 32'(overflow), 32'(m_ovf));
    chk({tag, "_busy"},     32'(busy),     32'd0);
  endtask

  // Monitor: every DUT output event consumes one expectation.
  logic [7:0] mon_e;
  always @(negedge clk) begin
    if (!rst) begin
      if (rd_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rd_valid_unexpected: rd_data=%0h with no read outstanding", rd_data);
        end else begin
          mon_e = exp_q.pop_front();
          checks--;
          chk("rd_data", 32'(rd_data), 32'(mon_e));
        end
      end
      if (rd_underflow === 1'b1) begin
        checks++;
        if (exp_uf == 0) begin
          errors++;
          $display("FAIL rd_underflow_unexpected: pulse seen, none outstanding");
        end else begin
          exp_uf--;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    logic [7:0] b;
    int op;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rd_valid",  32'(rd_valid),     32'd0);
    chk("rst_underflow", 32'(rd_underflow), 32'd0);
    chk("rst_count",     32'(count),        32'd0);
    chk("rst_empty",     32'(empty),        32'd1);
    chk("rst_full",      32'(full),         32'd0);
    chk("rst_overflow",  32'(overflow),     32'd0);
    chk("rst_busy",      32'(busy),         32'd0);
    chk("rst_wren",      32'(ram_wren),     32'd0);
    chk("rst_addr",      32'(ram_address),  32'd0);
    chk("rst_rd_data",   32'(rd_data),      32'd0);
    rst = 1'b0;
    chk_state("post_reset");

    // Asynchronous reset in the middle of a RAM write
    @(posedge clk); #1;
    key_data = 8'h2A;
    key_complete = 1'b1;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (ram_wren === 1'b1) seen = 1;
    end
    chk("rmw_wren_seen", 32'(seen), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("rmw_wren",  32'(ram_wren), 32'd0);
    chk("rmw_count", 32'(count),    32'd0);
    chk("rmw_empty", 32'(empty),    32'd1);
    key_complete = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    repeat (10) @(posedge clk);
    chk_state("rmw_after");

    // Break filtering
    press(8'h1C); press(8'hF0); press(8'h1C); press(8'h32);
    @(negedge clk);
    chk("brk_count", 32'(count), 32'd2);
    do_read(); do_read();
    chk_state("brk_after");

    // Fill past capacity, then drain (pointers wrap)
    for (int i = 1; i <= 33; i++) begin
      press(8'(i));
      if (i == 32) chk_state("fill32");
    end
    chk_state("fill33");
    for (int i = 0; i < 32; i++) do_read();
    chk_state("drain");

    // Read request coincident with key edge: write goes first
    press(8'h45);
    model_read();
    model_key(8'h51);
    @(posedge clk); #1;
    key_data = 8'h51;
    key_complete = 1'b1;
    repeat (2) @(posedge clk);
    #1 rd_req = 1'b1;
    @(posedge clk); #1 rd_req = 1'b0;
    @(negedge clk);
    chk("coinc_wren", 32'(ram_wren), 32'd1);
    repeat (2) @(posedge clk);
    #1 key_complete = 1'b0;
    repeat (10) @(posedge clk);
    chk_state("coinc");
    do_read();

    // Underflow
    do_read();
    chk_state("underflow");

    // Clear during RD_WAIT aborts the read
    press(8'h77);
    @(posedge clk); #1 rd_req = 1'b1;
    @(posedge clk); #1 rd_req = 1'b0;
    @(posedge clk); #1 clear = 1'b1;
    chk("clr_busy", 32'(busy), 32'd1);
    model_clear();
    @(posedge clk); #1 clear = 1'b0;
    repeat (8) @(posedge clk);
    chk_state("clr_rdwait");
    press(8'h3C);
    chk("clr_next_addr", 32'(last_wr_addr), 32'd0);
    chk_state("clr_next");
    do_read();

    // Randomized traffic
    for (int n = 0; n < 200; n++) begin
      op = $urandom_range(0, 99);
      if (op < 48) begin
        b = ($urandom_range(0, 7) == 0) ? 8'hF0 : 8'($urandom_range(0, 255));
        press(b);
      end else if (op < 95) begin
        do_read();
      end else begin
        do_clear();
      end
      if (n % 8 == 0) chk_state("rand");
    end
    chk_state("rand_end");

    repeat (10) @(posedge clk);
    chk("reads_outstanding",     32'(exp_q.size()), 32'd0);
    chk("underflow_outstanding", 32'(exp_uf),       32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
